// File: rtl/fft_peak_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : fft_peak_pkg
//  Description : Shared types and helpers for the FFT peak picker and its
//                consumers (state encoding, bin packing, silence constant).
//  Revision    : 1.0 - initial release
// ============================================================================
package fft_peak_pkg;

    // Frame tracking states of the peak picker.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACCUM = 2'd1,
        ST_EMIT  = 2'd2
    } state_t;

    // Bin index reported for a frame whose peak is below the magnitude floor.
    localparam logic [31:0] SILENCE_BIN = 32'd0;

    // Packs a complex sample into the FFT stream word: real high, imaginary low.
    function automatic logic [31:0] pack_bin(input logic signed [15:0] re,
                                             input logic signed [15:0] im);
        return {re, im};
    endfunction

endpackage
`default_nettype wire

// File: rtl/fft_peak_picker_if.sv
`default_nettype none
// ============================================================================
//  Module      : fft_peak_picker_if
//  Description : FFT bin stream in, per-frame peak result out. The master
//                side is the FFT core / consumer, the slave side the picker.
//  Revision    : 1.0 - initial release
// ============================================================================
interface fft_peak_picker_if;

    logic [31:0] fft_tdata;
    logic        fft_tvalid;
    logic        fft_tlast;
    logic [31:0] peak_bin;
    logic [31:0] peak_mag;
    logic        peak_valid;
    logic        peak_last;
    logic        frame_err;

    modport master (
        output fft_tdata, fft_tvalid, fft_tlast,
        input  peak_bin, peak_mag, peak_valid, peak_last, frame_err
    );

    modport slave (
        input  fft_tdata, fft_tvalid, fft_tlast,
        output peak_bin, peak_mag, peak_valid, peak_last, frame_err
    );

endinterface
`default_nettype wire

// File: rtl/fft_mag_sq.sv
`default_nettype none
// ============================================================================
//  Module      : fft_mag_sq
//  Description : Registered magnitude-squared of a packed complex sample
//                (re*re + im*im) with valid/last/index sideband; 1 cycle.
//  Revision    : 1.0 - initial release
// ============================================================================
module fft_mag_sq #(
    parameter int IDX_W = 10
) (
    input  wire              clk_in,
    input  wire              rst_in,
    input  wire              valid_i,
    input  wire              last_i,
    input  wire [IDX_W-1:0]  idx_i,
    input  wire [31:0]       data_i,
    output logic             valid_o,
    output logic             last_o,
    output logic [IDX_W-1:0] idx_o,
    output logic [31:0]      mag_o
);

    logic signed [15:0] w_re;
    logic signed [15:0] w_im;
    logic signed [31:0] w_re_sq;
    logic signed [31:0] w_im_sq;
    logic [31:0]        w_mag;

    logic               valid_q;
    logic               last_q;
    logic [IDX_W-1:0]   idx_q;
    logic [31:0]        mag_q;

    assign w_re    = data_i[31:16];
    assign w_im    = data_i[15:0];
    // Each square is at most 2^30, so the signed products never overflow;
    // the sum peaks at exactly 2^31 and is carried as unsigned.
    assign w_re_sq = w_re * w_re;
    assign w_im_sq = w_im * w_im;
    assign w_mag   = $unsigned(w_re_sq) + $unsigned(w_im_sq);

    // Pipeline register: bubbles pass through with valid low.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            valid_q <= 1'b0;
            last_q  <= 1'b0;
            idx_q   <= '0;
            mag_q   <= '0;
        end else begin
            valid_q <= valid_i;
            last_q  <= last_i & valid_i;
            idx_q   <= idx_i;
            mag_q   <= w_mag;
        end
    end

    assign valid_o = valid_q;
    assign last_o  = last_q;
    assign idx_o   = idx_q;
    assign mag_o   = mag_q;

endmodule
`default_nettype wire

// File: rtl/fft_peak_picker.sv
`default_nettype none
// ============================================================================
//  Module      : fft_peak_picker
//  Description : Finds the strongest bin inside [MIN_BIN, MAX_BIN] of each
//                FFT frame and reports its index and magnitude squared, or
//                silence when the peak is below MAG_FLOOR. Malformed frames
//                are discarded with a frame_err pulse.
//  Revision    : 1.0 - initial release
// ============================================================================
module fft_peak_picker
    import fft_peak_pkg::*;
#(
    parameter int          FFT_SIZE  = 1024,
    parameter int          MIN_BIN   = 2,
    parameter int          MAX_BIN   = 511,
    parameter logic [31:0] MAG_FLOOR = 32'd4096
) (
    input  wire              clk_in,
    input  wire              rst_in,
    fft_peak_picker_if.slave bus
);

    localparam int                 c_idx_w    = $clog2(FFT_SIZE);
    localparam logic [c_idx_w-1:0] c_last_idx = c_idx_w'(FFT_SIZE - 1);
    localparam logic [c_idx_w-1:0] c_min_bin  = c_idx_w'(MIN_BIN);
    localparam logic [c_idx_w-1:0] c_max_bin  = c_idx_w'(MAX_BIN);

    // Input bin counter
    logic [c_idx_w-1:0] cnt_q, cnt_d;

    // Stage-1 outputs
    logic               w_s1_valid;
    logic               w_s1_last;
    logic [c_idx_w-1:0] w_s1_idx;
    logic [31:0]        w_s1_mag;

    // Stage-2 state
    state_t             state_q, state_d;
    logic [31:0]        best_mag_q, best_mag_d;
    logic [c_idx_w-1:0] best_bin_q, best_bin_d;
    logic [31:0]        peak_bin_q, peak_bin_d;
    logic [31:0]        peak_mag_q, peak_mag_d;
    logic               peak_valid_q, peak_valid_d;
    logic               frame_err_q, frame_err_d;

    // Stage-2 combinational
    logic               w_in_window;
    logic               w_take;
    logic [31:0]        w_cand_mag;
    logic [c_idx_w-1:0] w_cand_bin;
    logic               w_frame_end;
    logic               w_frame_ok;
    logic               w_frame_bad;

    // Counter advances per accepted beat and restarts after tlast or on wrap.
    always_comb begin
        cnt_d = cnt_q;
        if (bus.fft_tvalid) begin
            if (bus.fft_tlast || (cnt_q == c_last_idx)) begin
                cnt_d = '0;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    // Counter register.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    fft_mag_sq #(
        .IDX_W (c_idx_w)
    ) u_mag_sq (
        .clk_in  (clk_in),
        .rst_in  (rst_in),
        .valid_i (bus.fft_tvalid),
        .last_i  (bus.fft_tlast),
        .idx_i   (cnt_q),
        .data_i  (bus.fft_tdata),
        .valid_o (w_s1_valid),
        .last_o  (w_s1_last),
        .idx_o   (w_s1_idx),
        .mag_o   (w_s1_mag)
    );

    // Strict greater-than with ascending bin order lets ties keep the lower bin.
    assign w_in_window = w_s1_valid && (w_s1_idx >= c_min_bin) && (w_s1_idx <= c_max_bin);
    assign w_take      = w_in_window && (w_s1_mag > best_mag_q);
    assign w_cand_mag  = w_take ? w_s1_mag : best_mag_q;
    assign w_cand_bin  = w_take ? w_s1_idx : best_bin_q;

    // A frame closes on tlast or on the final bin index; it is well formed
    // only when both coincide.
    assign w_frame_end = w_s1_valid && (w_s1_last || (w_s1_idx == c_last_idx));
    assign w_frame_ok  = w_frame_end && w_s1_last && (w_s1_idx == c_last_idx);
    assign w_frame_bad = w_frame_end && !w_frame_ok;

    // Next state, running best and result registers. The best is cleared as
    // the frame closes, so a bin arriving during EMIT already compares
    // against zero rather than the previous frame's peak.
    always_comb begin
        state_d      = state_q;
        best_mag_d   = w_cand_mag;
        best_bin_d   = w_cand_bin;
        peak_bin_d   = peak_bin_q;
        peak_mag_d   = peak_mag_q;
        peak_valid_d = 1'b0;
        frame_err_d  = 1'b0;

        case (state_q)
            ST_IDLE:  if (w_s1_valid) state_d = ST_ACCUM;
            ST_ACCUM: state_d = ST_ACCUM;
            ST_EMIT:  state_d = w_s1_valid ? ST_ACCUM : ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase

        if (w_frame_ok) begin
            state_d      = ST_EMIT;
            best_mag_d   = '0;
            best_bin_d   = '0;
            peak_valid_d = 1'b1;
            if (w_cand_mag < MAG_FLOOR) begin
                peak_bin_d = SILENCE_BIN;
                peak_mag_d = '0;
            end else begin
                peak_bin_d = 32'(w_cand_bin);
                peak_mag_d = w_cand_mag;
            end
        end else if (w_frame_bad) begin
            state_d     = ST_IDLE;
            best_mag_d  = '0;
            best_bin_d  = '0;
            frame_err_d = 1'b1;
        end
    end

    // Stage-2 registers; reset drops any partial frame silently.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q      <= ST_IDLE;
            best_mag_q   <= '0;
            best_bin_q   <= '0;
            peak_bin_q   <= '0;
            peak_mag_q   <= '0;
            peak_valid_q <= 1'b0;
            frame_err_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            best_mag_q   <= best_mag_d;
            best_bin_q   <= best_bin_d;
            peak_bin_q   <= peak_bin_d;
            peak_mag_q   <= peak_mag_d;
            peak_valid_q <= peak_valid_d;
            frame_err_q  <= frame_err_d;
        end
    end

    assign bus.peak_bin   = peak_bin_q;
    assign bus.peak_mag   = peak_mag_q;
    assign bus.peak_valid = peak_valid_q;
    assign bus.peak_last  = peak_valid_q;
    assign bus.frame_err  = frame_err_q;

endmodule
`default_nettype wire
